// File: rtl/hacd_pkg.sv
// Shared AXI read packet types and constants for the HACD block family.
// Also holds the burst FSM state type and the clogb2 helper.
package hacd_pkg;

  localparam logic [63:0] HPPA_BASE_ADDR = 64'h0000_0000_8000_0000;
  localparam int BLK_SIZE = 64;

  parameter logic [1:0] RESP_OKAY   = 2'b00;
  parameter logic [1:0] RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic [63:0] addr;
    logic [7:0]  arlen;
    logic        arvalid;
    logic        rready;
  } axi_rd_reqpkt_t;

  typedef struct packed {
    logic arready;
  } axi_rd_rdypkt_t;

  typedef struct packed {
    logic [1:0]   rresp;
    logic [511:0] rdata;
    logic         rvalid;
    logic         rlast;
  } axi_rd_resppkt_t;

  typedef enum logic {
    IDLE,
    BURST
  } rd_state_e;

  function automatic int clogb2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/hawk_line_ram.sv
// Line storage: one write port, one registered read port.
// Contents are not reset; the read register holds when re is low.
module hawk_line_ram #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk_i,
  input  logic          we,
  input  logic [AW-1:0] widx,
  input  logic [511:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] ridx,
  output logic [511:0]  rdata
);

  logic [511:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we) mem[widx] <= wdata;
  end

  always_ff @(posedge clk_i) begin
    if (re) rdata <= mem[ridx];
  end

endmodule

// File: rtl/hawk_axird_responder.sv
// AXI read slave serving INCR bursts of 64-byte lines from a preloadable RAM.
// Out-of-range lines return SLVERR with zero data and are counted.
module hawk_axird_responder
  import hacd_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR = HPPA_BASE_ADDR,
  parameter int          MEM_DEPTH = 64
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  axi_rd_reqpkt_t                rd_reqpkt,
  output axi_rd_rdypkt_t                rd_rdypkt,
  output axi_rd_resppkt_t               rd_resppkt,
  input  logic                          init_we,
  input  logic [clogb2(MEM_DEPTH)-1:0]  init_idx,
  input  logic [511:0]                  init_data,
  output logic                          busy,
  output logic [15:0]                   err_cnt
);

  localparam int AW  = clogb2(MEM_DEPTH);
  localparam int LSH = $clog2(BLK_SIZE);

  rd_state_e    state, state_d;
  logic [7:0]   len_q, beat_q;
  logic [63:0]  line_q, off, rd_line;
  logic         rvalid_q, rlast_q, ok_q;
  logic [1:0]   rresp_q;
  logic [15:0]  err_q;
  logic [511:0] ram_q;
  logic         ar_hs, r_hs, rd_ok, rd_en, wr_ok;

  assign off   = (rd_reqpkt.addr - BASE_ADDR) >> LSH;
  assign ar_hs = (state == IDLE) && rd_reqpkt.arvalid;
  assign r_hs  = rvalid_q && rd_reqpkt.rready;

  // Next line is fetched on the handshake so rvalid never drops mid-burst.
  assign rd_line = ar_hs ? off : line_q + 64'd1;
  assign rd_ok   = rd_line < 64'(MEM_DEPTH);
  assign rd_en   = rd_ok && (ar_hs || (r_hs && !rlast_q));
  assign wr_ok   = 32'(init_idx) < 32'(MEM_DEPTH);

  hawk_line_ram #(
    .DEPTH (MEM_DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk_i (clk_i),
    .we    (init_we && wr_ok),
    .widx  (init_idx),
    .wdata (init_data),
    .re    (rd_en),
    .ridx  (rd_line[AW-1:0]),
    .rdata (ram_q)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:  if (rd_reqpkt.arvalid) state_d = BURST;
      BURST: if (r_hs && rlast_q)   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      len_q    <= '0;
      beat_q   <= '0;
      line_q   <= '0;
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
      rresp_q  <= RESP_OKAY;
      ok_q     <= 1'b0;
      err_q    <= '0;
    end else if (ar_hs) begin
      len_q    <= rd_reqpkt.arlen;
      beat_q   <= '0;
      line_q   <= off;
      rvalid_q <= 1'b1;
      rlast_q  <= rd_reqpkt.arlen == 8'd0;
      rresp_q  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
      ok_q     <= rd_ok;
    end else if (r_hs) begin
      if (rlast_q) begin
        rvalid_q <= 1'b0;
        rlast_q  <= 1'b0;
      end else begin
        beat_q  <= beat_q + 8'd1;
        line_q  <= rd_line;
        rlast_q <= (beat_q + 8'd1) == len_q;
        rresp_q <= rd_ok ? RESP_OKAY : RESP_SLVERR;
        ok_q    <= rd_ok;
      end
      if (rresp_q == RESP_SLVERR && err_q != 16'hFFFF)
        err_q <= err_q + 16'd1;
    end
  end

  assign rd_rdypkt  = '{arready: (state == IDLE)};
  assign rd_resppkt = '{
    rresp:  rresp_q,
    rdata:  ok_q ? ram_q : '0,
    rvalid: rvalid_q,
    rlast:  rlast_q
  };
  assign busy    = state == BURST;
  assign err_cnt = err_q;

endmodule

// File: tb/tb_hawk_axird_responder.sv
// Bench for hawk_axird_responder: directed bursts plus random bursts
// checked beat-by-beat against a line-array reference model.
module tb_hawk_axird_responder;
  import hacd_pkg::*;

  localparam logic [63:0] BASE  = HPPA_BASE_ADDR;
  localparam int          DEPTH = 64;
  localparam int          LIMIT = 3000;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  axi_rd_reqpkt_t  req;
  axi_rd_rdypkt_t  rdy;
  axi_rd_resppkt_t rsp;
  logic            init_we;
  logic [5:0]      init_idx;
  logic [511:0]    init_data;
  logic            busy;
  logic [15:0]     err_cnt;

  logic [511:0] mdl [DEPTH];
  int n_chk = 0;
  int n_err = 0;
  int err_exp = 0;

  always #5 clk = ~clk;

  hawk_axird_responder #(
    .BASE_ADDR (BASE),
    .MEM_DEPTH (DEPTH)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .rd_reqpkt  (req),
    .rd_rdypkt  (rdy),
    .rd_resppkt (rsp),
    .init_we    (init_we),
    .init_idx   (init_idx),
    .init_data  (init_data),
    .busy       (busy),
    .err_cnt    (err_cnt)
  );

  task automatic chk(input string tag, input logic [511:0] got,
                     input logic [511:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] rnd_line();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [63:0] beat_line(input logic [63:0] a,
                                            input int b);
    return ((a - BASE) >> 6) + 64'(b);
  endfunction

  task automatic load(input int idx, input logic [511:0] d);
    init_we   = 1'b1;
    init_idx  = idx[5:0];
    init_data = d;
    @(negedge clk);
    init_we = 1'b0;
    mdl[idx] = d;
  endtask

  // mode: 0 rready=1, 1 toggle, 2 random, 3 stall beat 0 and rewrite line 1
  task automatic burst(input logic [63:0] a, input int len,
                       input int mode, input int abort_at);
    int beat = 0;
    int cyc = 0;
    logic [63:0] ln, ln1;
    logic ok, rr;
    logic [511:0] nd;
    chk("arready_idle", rdy.arready, 1);
    req.addr    = a;
    req.arlen   = len[7:0];
    req.arvalid = 1'b1;
    req.rready  = 1'b0;
    @(negedge clk);
    req.arvalid = 1'b0;
    while (beat <= len && cyc < LIMIT) begin
      if (beat == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk("rst_rvalid", rsp.rvalid, 0);
        chk("rst_rlast", rsp.rlast, 0);
        chk("rst_rdata", rsp.rdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err_cnt", err_cnt, 0);
        err_exp = 0;
        req.rready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_arready", rdy.arready, 1);
        chk("rel_rvalid", rsp.rvalid, 0);
        return;
      end
      ln = beat_line(a, beat);
      ok = ln < 64'(DEPTH);
      chk("rvalid", rsp.rvalid, 1);
      chk("busy", busy, 1);
      chk("rdata", rsp.rdata, ok ? mdl[ln[5:0]] : '0);
      chk("rresp", rsp.rresp, ok ? RESP_OKAY : RESP_SLVERR);
      chk("rlast", rsp.rlast, beat == len);
      if (mode == 3 && cyc == 1) begin
        ln1 = beat_line(a, 1);
        nd  = rnd_line();
        init_we   = 1'b1;
        init_idx  = ln1[5:0];
        init_data = nd;
        mdl[ln1[5:0]] = nd;
      end
      if (mode == 3 && cyc == 2) init_we = 1'b0;
      case (mode)
        0: rr = 1'b1;
        1: rr = (cyc % 2) == 1;
        2: rr = $urandom_range(0, 2) != 0;
        default: rr = cyc >= 3;
      endcase
      req.rready = rr;
      if (rr) begin
        if (!ok && err_exp < 65535) err_exp++;
        beat++;
      end
      cyc++;
      @(negedge clk);
    end
    req.rready = 1'b0;
    chk("timeout", cyc < LIMIT, 1);
    chk("end_rvalid", rsp.rvalid, 0);
    chk("end_rlast", rsp.rlast, 0);
    chk("end_arready", rdy.arready, 1);
    chk("end_busy", busy, 0);
    chk("err_cnt", err_cnt, err_exp);
  endtask

  initial begin
    int lo;
    logic [63:0] a;
    req       = '0;
    init_we   = 1'b0;
    init_idx  = '0;
    init_data = '0;
    repeat (3) @(negedge clk);
    chk("reset_rvalid", rsp.rvalid, 0);
    chk("reset_rlast", rsp.rlast, 0);
    chk("reset_rdata", rsp.rdata, 0);
    chk("reset_rresp", rsp.rresp, 0);
    chk("reset_busy", busy, 0);
    chk("reset_err_cnt", err_cnt, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_arready", rdy.arready, 1);

    for (int i = 0; i < DEPTH; i++) load(i, rnd_line());
    for (int i = 0; i < 4; i++) load(i, {16{32'hA5A5_0000 + 32'(i)}});

    burst(BASE, 3, 0, -1);
    burst(BASE + 64'd5 * 64, 1, 1, -1);
    burst(BASE + 64'd62 * 64, 3, 0, -1);
    chk("err_cnt_edge", err_cnt, 2);
    burst(BASE - 64'd64, 0, 0, -1);
    burst(BASE + 64'd10 * 64, 1, 3, -1);
    burst(BASE, 7, 0, 2);
    burst(BASE + 64'd20 * 64, 7, 2, -1);

    for (int i = 0; i < 14; i++) begin
      lo = int'($urandom_range(0, 75)) - 4;
      a  = BASE + 64'(longint'(lo) * 64) + 64'($urandom_range(0, 63));
      burst(a, int'($urandom_range(0, 12)), int'($urandom_range(0, 2)), -1);
    end
    burst(BASE + 64'd60 * 64, 255, 0, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/hawk_axird_responder.md
HAWK_AXIRD_RESPONDER -- requirements
Module: hawk_axird_responder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default HPPA_BASE_ADDR: byte address of line 0.
REQ-002 SHALL have parameter MEM_DEPTH, default 64: number of 64-byte lines held.
REQ-003 SHALL have port clk_i, input, 1: single clock; all logic is rising-edge.
REQ-004 SHALL have port rst_ni, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port rd_reqpkt, input, axi_rd_reqpkt_t: addr, arlen, arvalid and rready from the read master.
REQ-006 SHALL have port rd_rdypkt, output, axi_rd_rdypkt_t: arready.
REQ-007 SHALL have port rd_resppkt, output, axi_rd_resppkt_t: rresp, rdata, rvalid and rlast.
REQ-008 SHALL have port init_we, input, 1: preload write enable.
REQ-009 SHALL have port init_idx, input, clogb2(MEM_DEPTH): preload line index.
REQ-010 SHALL have port init_data, input, 512: preload line data.
REQ-011 SHALL have port busy, output, 1: high while a burst is outstanding.
REQ-012 SHALL have port err_cnt, output, 16: count of SLVERR beats.

Function
REQ-013 SHALL implement FSM states IDLE and BURST; reset state is IDLE.
REQ-014 SHALL drive arready=1 only in IDLE (combinational from state).
REQ-015 SHALL, on arvalid&&arready in IDLE, capture addr and arlen, set beat counter=0, and go to BURST.
REQ-016 SHALL present the first beat with rvalid=1 in the cycle after the AR handshake (one-cycle latency).
REQ-017 SHALL compute line offset=(addr-BASE_ADDR)>>6 in 64-bit arithmetic, ignoring addr[5:0]; each beat's line is offset+beat (INCR burst).
REQ-018 SHALL return, for a beat whose line is within [0, MEM_DEPTH-1], rdata=mem[line] and rresp=2'b00 (OKAY).
REQ-019 SHALL return, for a beat whose line is outside that range (including addr<BASE_ADDR via unsigned wrap), rdata=0 and rresp=2'b10 (SLVERR); no index wrap-around.
REQ-020 SHALL assert rlast with the beat numbered arlen; a burst is arlen+1 beats, up to 256.
REQ-021 SHALL advance a beat only on rvalid&&rready, and hold rdata, rresp and rlast stable while rvalid&&!rready.
REQ-022 SHALL keep rvalid continuously high between beats within a burst (next beat registered on the handshake cycle).
REQ-023 SHALL, on the rlast handshake, drop rvalid and rlast and return to IDLE, so arready=1 in the following cycle (one bubble between bursts).
REQ-024 SHALL write init_data into mem[init_idx] at the clock edge when init_we=1; writes are accepted in any state.
REQ-025 SHALL NOT alter a beat already presented (registered) when init_we hits its line; later beats of the burst see the new data.
REQ-026 SHALL ignore init_idx>=MEM_DEPTH.
REQ-027 SHALL increment err_cnt on every SLVERR beat handshake, saturating at 16'hFFFF.
REQ-028 SHALL set busy=1 exactly when state==BURST.

Reset
REQ-029 SHALL, while rst_ni=0, force: state=IDLE, rvalid=0, rlast=0, rdata=0, rresp=0, err_cnt=0, busy=0, beat counter=0.
REQ-030 SHALL drive arready=1 from the first cycle after reset release.
REQ-031 SHALL abandon a burst on mid-burst reset, with no further beats after release.
REQ-032 SHALL NOT reset memory contents; they are undefined until preloaded.

Structure
REQ-033 SHALL reuse the axi_rd_* packet types, HPPA_BASE_ADDR, BLK_SIZE and clogb2 from hacd_pkg.
REQ-034 SHALL add parameters RESP_OKAY=2'b00 and RESP_SLVERR=2'b10 to hacd_pkg.
REQ-035 SHALL place the line storage in sub-module hawk_line_ram (1 write port, 1 registered read port); all other logic stays in the top.

Verification
REQ-036 SHALL cover: preload lines 0-3 with distinct patterns, addr=BASE_ADDR, arlen=3, rready=1 -> 4 consecutive OKAY beats with lines 0..3, rlast on 4th, arready back 1 cycle later.
REQ-037 SHALL cover: arlen=1, rready toggled 0/1 each cycle -> each beat held stable while stalled, exactly 2 handshakes, rlast only on 2nd.
REQ-038 SHALL cover: addr=BASE_ADDR+62*64, arlen=3, MEM_DEPTH=64 -> beats 0-1 OKAY, beats 2-3 SLVERR with rdata=0, err_cnt=2.
REQ-039 SHALL cover: addr=BASE_ADDR-64, arlen=0 -> single SLVERR beat with rlast=1.
REQ-040 SHALL cover: init_we to line 1 while beat 0 of a 2-beat burst is stalled -> beat 1 returns the new data.
REQ-041 SHALL cover: rst_ni asserted mid-burst at beat 2 of 8 -> rvalid=0 immediately, arready=1 after release, next burst correct.
